// File: rtl/fifo_arb_pkg.sv
// Shared FSM state type, default parameters and round-robin index helper
// for the FIFO write arbiter.
package fifo_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      STALL = 2'd2
   } arb_state_t;

   localparam int NREQ_DEF      = 4;
   localparam int DW_DEF        = 8;
   localparam int BURST_MAX_DEF = 4;

   // k-th requester after 'last' in rotation order (k = NREQ wraps back to 'last')
   function automatic int rr_next(input int last, input int k, input int n);
      return (last + k) % n;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: requester (last_owner+1) mod NREQ has the
// highest priority and last_owner itself the lowest.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   last_owner,
   output logic [NREQ-1:0] pick,
   output logic [IW-1:0]   pick_idx
);

   logic [IW-1:0] cand;

   // scan from lowest to highest priority so the final hit is the winner
   always_comb begin
      pick     = '0;
      pick_idx = last_owner;
      cand     = '0;
      for (int k = NREQ; k >= 1; k--) begin
         cand     = IW'(rr_next(int'(last_owner), k, NREQ));
         pick     = req[cand] ? (NREQ'(1) << cand) : pick;
         pick_idx = req[cand] ? cand : pick_idx;
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter feeding one FIFO write port from NREQ requesters.
// Define FIFO_WR_ARB_STATS_EN to add the saturating stall_cnt output.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NREQ      = NREQ_DEF,
   parameter int DW        = DW_DEF,
   parameter int BURST_MAX = BURST_MAX_DEF
) (
   input  logic                    wclk,
   input  logic                    wrst,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*DW-1:0]      req_data,
   output logic [NREQ-1:0]         gnt,
   input  logic                    wfull,
   input  logic                    afull,
   output logic                    winc,
   output logic [DW-1:0]           wdata,
   output logic [$clog2(NREQ)-1:0] owner
`ifdef FIFO_WR_ARB_STATS_EN
   ,
   output logic [15:0]             stall_cnt
`endif
);

   localparam int IW = $clog2(NREQ);
   localparam int CW = $clog2(BURST_MAX + 1);
   localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_MAX - 1);

   arb_state_t    state;
   arb_state_t    state_nxt;
   logic [IW-1:0] owner_nxt;
   logic [CW-1:0] beat_cnt;
   logic [CW-1:0] beat_nxt;
   logic [NREQ-1:0] pick;
   logic [IW-1:0] pick_idx;
   logic          found;
   logic          ok;
   logic          accept;
   logic          arb;
   logic [DW-1:0] data_arr [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_data
      assign data_arr[g] = req_data[g*DW +: DW];
   end

   // a write already in flight consumes the last free slot signalled by afull
   assign ok    = !wfull && !(afull && winc);
   assign found = |pick;

   rr_pick #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_rr_pick (
      .req        (req),
      .last_owner (owner),
      .pick       (pick),
      .pick_idx   (pick_idx)
   );

   // next state, grant and burst bookkeeping; arb re-arbitrates in this same cycle
   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      beat_nxt  = beat_cnt;
      gnt       = '0;
      accept    = 1'b0;
      arb       = 1'b0;
      case (state)
         IDLE: begin
            arb = 1'b1;
         end
         BURST, STALL: begin
            if (req[owner] && ok) begin
               gnt[owner] = 1'b1;
               accept     = 1'b1;
               if (beat_cnt == LAST_BEAT) begin
                  arb = 1'b1;
               end else begin
                  state_nxt = BURST;
                  beat_nxt  = beat_cnt + CW'(1);
               end
            end else if (req[owner]) begin
               state_nxt = STALL;
            end else begin
               arb = 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
      state_nxt = arb ? (found ? BURST : IDLE) : state_nxt;
      owner_nxt = (arb && found) ? pick_idx : owner_nxt;
      beat_nxt  = arb ? '0 : beat_nxt;
   end

   // state, owner and registered FIFO write port
   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         state    <= IDLE;
         owner    <= IW'(NREQ - 1);
         beat_cnt <= '0;
         winc     <= 1'b0;
         wdata    <= '0;
      end else begin
         state    <= state_nxt;
         owner    <= owner_nxt;
         beat_cnt <= beat_nxt;
         winc     <= accept;
         if (accept) begin
            wdata <= data_arr[owner];
         end
      end
   end

`ifdef FIFO_WR_ARB_STATS_EN
   // saturating count of cycles spent waiting in STALL
   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         stall_cnt <= 16'h0000;
      end else if (state == STALL && stall_cnt != 16'hFFFF) begin
         stall_cnt <= stall_cnt + 16'h0001;
      end
   end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: requesters with fixed beat counts, a
// 16-deep FIFO occupancy model, and a burst-level round-robin reference model.
module tb_fifo_wr_arbiter;

   localparam int NREQ  = 4;
   localparam int DW    = 8;
   localparam int BM    = 4;
   localparam int IW    = 2;
   localparam int DEPTH = 16;

   logic               wclk = 1'b0;
   logic               wrst;
   logic [NREQ-1:0]    req;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]    gnt;
   logic               wfull;
   logic               afull;
   logic               winc;
   logic [DW-1:0]      wdata;
   logic [IW-1:0]      owner;
`ifdef FIFO_WR_ARB_STATS_EN
   logic [15:0]        stall_cnt;
`endif

   int total = 0;
   int bad   = 0;
   logic [DW-1:0] exp_q[$];
   int   model_last;
   int   fifo_cnt;
   int   rem [NREQ];
   int   sent[NREQ];
   logic acc_prev;
   int   nw, first_w, last_w;

   fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .BURST_MAX(BM)) dut (
      .wclk     (wclk),
      .wrst     (wrst),
      .req      (req),
      .req_data (req_data),
      .gnt      (gnt),
      .wfull    (wfull),
      .afull    (afull),
      .winc     (winc),
      .wdata    (wdata),
      .owner    (owner)
`ifdef FIFO_WR_ARB_STATS_EN
      ,
      .stall_cnt(stall_cnt)
`endif
   );

   always #5 wclk = ~wclk;

   function automatic logic [DW-1:0] beat_data(input int i, input int b);
      return DW'(i * 32 + (b % 32));
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Whole-batch reference: rotate from the last served requester, each turn
   // takes min(BM, remaining) beats, empty requesters are skipped.
   function automatic void model_push();
      int  left[NREQ];
      int  done[NREQ];
      int  p, n, i;
      bit  hit;
      for (int k = 0; k < NREQ; k++) begin
         left[k] = rem[k];
         done[k] = 0;
      end
      p   = model_last;
      i   = 0;
      hit = 1'b1;
      while (hit) begin
         hit = 1'b0;
         for (int k = 1; k <= NREQ && !hit; k++) begin
            i = (p + k) % NREQ;
            if (left[i] > 0) hit = 1'b1;
         end
         if (hit) begin
            n = (left[i] < BM) ? left[i] : BM;
            for (int b = 0; b < n; b++) exp_q.push_back(beat_data(i, done[i] + b));
            done[i] += n;
            left[i] -= n;
            p = i;
         end
      end
      model_last = p;
   endfunction

   task automatic do_reset();
      wrst  = 1'b1;
      req   = '1;
      wfull = 1'b0;
      afull = 1'b0;
      exp_q.delete();
      fifo_cnt   = 0;
      acc_prev   = 1'b0;
      model_last = NREQ - 1;
      for (int k = 0; k < NREQ; k++) begin
         rem[k]  = 0;
         sent[k] = 0;
      end
      for (int c = 0; c < 3; c++) begin
         #1;
         check("rst_gnt", gnt, 0);
         check("rst_winc", winc, 0);
         check("rst_wdata", wdata, 0);
         check("rst_owner", owner, NREQ - 1);
         @(negedge wclk);
      end
      wrst = 1'b0;
      #1;
      check("release_gnt", gnt, 0);
   endtask

   task automatic set_rem(input int a, input int b, input int c, input int d);
      rem[0] = a; rem[1] = b; rem[2] = c; rem[3] = d;
      for (int k = 0; k < NREQ; k++) sent[k] = 0;
   endtask

   task automatic run_batch(input int drain_pct, input int stall_req, input int abort_at);
      int cyc = 0;
      int tail = 0;
      int fl = 0;
      bit stall_done = 1'b0;
      bit busy;
      logic [NREQ-1:0] acc;
      nw = 0; first_w = -1; last_w = -1;
      model_push();
      while (tail < 3) begin
         @(negedge wclk);
         if (abort_at != 0 && cyc == abort_at) begin
            do_reset();
            return;
         end
         if (winc) begin
            check("fifo_overflow", fifo_cnt < DEPTH, 1);
            if (fifo_cnt < DEPTH) fifo_cnt++;
            nw++;
            if (first_w < 0) first_w = cyc;
            last_w = cyc;
         end
         if (fifo_cnt > 0 && $urandom_range(0, 99) < drain_pct) fifo_cnt--;
         if (stall_req >= 0 && !stall_done && sent[stall_req] == 2) begin
            fl = 10;
            stall_done = 1'b1;
         end
         wfull = (fl > 0) || (fifo_cnt >= DEPTH);
         afull = (fifo_cnt >= DEPTH - 1);
         for (int k = 0; k < NREQ; k++) begin
            req[k] = (rem[k] > 0);
            req_data[k*DW +: DW] = (rem[k] > 0) ? beat_data(k, sent[k]) : DW'($urandom);
         end
         #1;
         check("winc_latency", winc, acc_prev);
         check("gnt_onehot", $onehot0(gnt), 1);
         check("gnt_without_req", gnt & ~req, 0);
         if (wfull) check("gnt_while_full", gnt, 0);
         else if (afull && winc) check("gnt_while_afull_winc", gnt, 0);
         else if (gnt != '0) check("gnt_owner", gnt, 32'(1) << owner);
         acc = req & gnt;
         for (int k = 0; k < NREQ; k++) begin
            if (acc[k]) begin
               sent[k]++;
               rem[k]--;
            end
         end
         acc_prev = |acc;
         if (fl > 0) fl--;
         cyc++;
         busy = 1'b0;
         for (int k = 0; k < NREQ; k++) if (rem[k] > 0) busy = 1'b1;
         if (!busy && exp_q.size() == 0) tail++;
         if (cyc > 2000) begin
            check("batch_drain", exp_q.size(), 0);
            do_reset();
            return;
         end
      end
   endtask

   // monitor: every FIFO write must match the head of the expected queue
   initial begin
      logic [DW-1:0] e;
      forever begin
         @(negedge wclk);
         #2;
         if (winc === 1'b1) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_write: got wdata %0h expected no write at %0t", wdata, $time);
            end else begin
               e = exp_q.pop_front();
               check("wdata", wdata, e);
            end
         end
      end
   end

   initial begin
      wrst     = 1'b1;
      req      = '1;
      req_data = '0;
      wfull    = 1'b0;
      afull    = 1'b0;
      @(negedge wclk);
      do_reset();

      // rotation 0,1,2,3,0,... with a continuous write stream
      set_rem(8, 8, 8, 8);
      run_batch(100, -1, 0);
      check("rotation_writes", nw, 32);
      check("rotation_span", last_w - first_w + 1, 32);

      // full stall on requester 2's third beat
      set_rem(4, 4, 4, 4);
      run_batch(100, 2, 0);
`ifdef FIFO_WR_ARB_STATS_EN
      check("stall_cnt", stall_cnt, 10);
`endif

      // requester 1 drops after 2 beats
      set_rem(4, 2, 0, 3);
      run_batch(100, -1, 0);

      // slow drain drives the FIFO into afull/wfull
      set_rem(10, 10, 10, 10);
      run_batch(5, -1, 0);

      // reset in the middle of a burst
      set_rem(6, 6, 6, 6);
      run_batch(100, -1, 7);
      set_rem(3, 5, 1, 2);
      run_batch(100, -1, 0);

      for (int t = 0; t < 25; t++) begin
         set_rem($urandom_range(0, 10), $urandom_range(0, 10),
                 $urandom_range(0, 10), $urandom_range(0, 10));
         run_batch($urandom_range(10, 100), -1, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of write requesters (2..8).
REQ-002 Parameter DW, default 8, data width, matching the FIFO wdata width.
REQ-003 Parameter BURST_MAX, default 4, maximum beats per grant before rotation (1..15).
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset: wclk is the single clock and wrst is the reset.
REQ-005 wclk  in  1  write-domain clock; all state updates on its rising edge.
REQ-006 wrst  in  1  asynchronous active-high reset.
REQ-007 req  in  NREQ  per-requester valid, held until accepted.
REQ-008 req_data  in  NREQ*DW  requester i data at bits [i*DW +: DW].
REQ-009 gnt  out  NREQ  one-hot accept strobe; a beat transfers when req[i] and gnt[i] are both high.
REQ-010 wfull  in  1  FIFO full flag.
REQ-011 afull  in  1  FIFO almost-full flag, meaning at most one free slot.
REQ-012 winc  out  1  registered FIFO write strobe.
REQ-013 wdata  out  DW  registered FIFO write data.
REQ-014 owner  out  clog2(NREQ)  index of the current or last granted requester.

Function
REQ-015 FSM states: IDLE, BURST, STALL.
REQ-016 In IDLE, with any req high, the block SHALL pick the first requester at or after (last_owner+1) mod NREQ and enter BURST with beat_cnt=0.
REQ-017 The accept condition is ok = !wfull && !(afull && winc).
REQ-018 In BURST, gnt[owner] = req[owner] && ok, combinationally; all other gnt bits SHALL be 0.
REQ-019 On an accepted beat, the block SHALL set winc=1 and wdata=req_data[owner] on the next edge, giving one-cycle latency; otherwise winc=0 and wdata holds.
REQ-020 In BURST, with req[owner] high and ok low, the FSM SHALL go to STALL; STALL returns to BURST when ok rises, and the grant is kept.
REQ-021 The burst ends when beat_cnt reaches BURST_MAX-1 on an accepted beat, or when req[owner] drops. It then re-arbitrates in the same cycle using the rotated priority, or enters IDLE if no req is high.
REQ-022 The arbiter SHALL be work-conserving: no idle cycle between bursts while any req is high and ok is high.
REQ-023 Priority SHALL be round-robin; the requester just served gets lowest priority.
REQ-024 A single requester SHALL get back-to-back bursts with no gap.
REQ-025 gnt SHALL never be asserted while wfull=1.
REQ-026 gnt SHALL never be asserted while afull=1 and winc=1, so the FIFO cannot overflow.
REQ-027 beat_cnt SHALL be clog2(BURST_MAX+1) bits wide and SHALL never wrap inside a burst.

Reset
REQ-028 While wrst=1, the block SHALL hold: state=IDLE, gnt=0, winc=0, wdata=0, owner=NREQ-1 (so requester 0 wins first), beat_cnt=0.
REQ-029 Reset asserted mid-burst SHALL abort it immediately; any beat in flight is dropped.
REQ-030 The first grant after reset release SHALL be no earlier than the second rising wclk edge.

Configuration
REQ-031 Macro FIFO_WR_ARB_STATS_EN.
REQ-032 When FIFO_WR_ARB_STATS_EN is defined, the block SHALL add output stall_cnt [15:0].
REQ-033 stall_cnt SHALL increment each cycle in STALL, saturate at 16'hFFFF, and reset to 0.
REQ-034 When FIFO_WR_ARB_STATS_EN is undefined, the port and logic SHALL be absent and all other behaviour unchanged.

Structure
REQ-035 Shared package fifo_arb_pkg SHALL hold the FSM state enum (IDLE, BURST, STALL) and the default constants for NREQ, DW and BURST_MAX.
REQ-036 One combinational sub-module, rr_pick, SHALL take (req, last_owner) and return the one-hot pick plus its index.

Verification
REQ-037 Reset: wrst=1 for 3 cycles with req=4'b1111 -> gnt=0 and winc=0 throughout; after release, owner=0 is granted first.
REQ-038 Rotation: all 4 req held, BURST_MAX=4, FIFO empty -> 4 beats each in order 0,1,2,3,0; winc=1 continuously, with no gap cycles.
REQ-039 Full stall: wfull=1 during requester 2's beat 2 -> gnt=0 and FSM in STALL; on wfull=0, requester 2 completes beats 2..3 and then the grant rotates to 3.
REQ-040 Almost-full: afull=1 with winc=1 -> gnt low for 1 cycle; no write occurs once wfull=1, and the FIFO never overflows (16-deep model).
REQ-041 Early drop: requester 1 drops req after 2 beats -> the grant moves to the next pending requester in the same cycle.
REQ-042 Stats: with FIFO_WR_ARB_STATS_EN defined, holding wfull=1 for 10 cycles with req pending -> stall_cnt=10.
